// File: rtl/pc_redirect_ctrl_if.sv
// Fetch-redirect bundle between the pipeline (master) and pc_redirect_ctrl (slave).
// taken_count exists only when PC_BRANCH_STATS_EN is defined.
interface pc_redirect_ctrl_if;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] pc;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        redirect_busy;
    logic        target_misaligned;
`ifdef PC_BRANCH_STATS_EN
    logic [15:0] taken_count;
`endif

    modport master (
        output branch_taken, branch_target, stall,
        input  pc, if_id_flush, id_ex_flush, redirect_busy, target_misaligned
`ifdef PC_BRANCH_STATS_EN
        , input taken_count
`endif
    );

    modport slave (
        input  branch_taken, branch_target, stall,
        output pc, if_id_flush, id_ex_flush, redirect_busy, target_misaligned
`ifdef PC_BRANCH_STATS_EN
        , output taken_count
`endif
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC register with branch redirect and a fixed-length pipeline flush window.
// Optional saturating taken-branch counter enabled by PC_BRANCH_STATS_EN.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    pc_redirect_ctrl_if.slave       bus
);
    typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      state_r, state_s;
    logic [2:0]  flush_cnt_r, flush_cnt_s;
    logic [31:0] pc_r, pc_s;
    logic        accept_s;
    logic        misaligned_s;
    logic        flush_r;
    logic        misaligned_r;

    // Next-state, next-PC and redirect acceptance
    always_comb begin
        state_s      = state_r;
        flush_cnt_s  = flush_cnt_r;
        pc_s         = pc_r;
        accept_s     = 1'b0;
        misaligned_s = 1'b0;
        case (state_r)
            RUN: begin
                // A branch wins over stall: the held instruction is on the wrong path anyway.
                if (bus.branch_taken) begin
                    accept_s     = 1'b1;
                    pc_s         = {bus.branch_target[31:2], 2'b00};
                    state_s      = FLUSH;
                    flush_cnt_s  = FLUSH_INIT;
                    misaligned_s = |bus.branch_target[1:0];
                end else if (bus.stall) begin
                    pc_s = pc_r;
                end else begin
                    pc_s = pc_r + 32'd4;
                end
            end
            FLUSH: begin
                if (bus.stall) begin
                    pc_s = pc_r;
                end else begin
                    pc_s = pc_r + 32'd4;
                end
                if (flush_cnt_r == 3'd0) begin
                    state_s     = RUN;
                    flush_cnt_s = 3'd0;
                end else begin
                    flush_cnt_s = flush_cnt_r - 3'd1;
                end
            end
            default: begin
                state_s     = RUN;
                flush_cnt_s = 3'd0;
                pc_s        = pc_r;
            end
        endcase
    end

    // State, PC and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= RUN;
            flush_cnt_r  <= 3'd0;
            pc_r         <= RESET_PC;
            flush_r      <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            flush_cnt_r  <= flush_cnt_s;
            pc_r         <= pc_s;
            flush_r      <= (state_s == FLUSH);
            misaligned_r <= misaligned_s;
        end
    end

    assign bus.pc                = pc_r;
    assign bus.if_id_flush       = flush_r;
    assign bus.id_ex_flush       = flush_r;
    assign bus.redirect_busy     = flush_r;
    assign bus.target_misaligned = misaligned_r;

`ifdef PC_BRANCH_STATS_EN
    logic [15:0] taken_count_r;

    // Saturating count of accepted branches
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_count_r <= 16'h0000;
        end else if (accept_s && (taken_count_r != 16'hFFFF)) begin
            taken_count_r <= taken_count_r + 16'd1;
        end else begin
            taken_count_r <= taken_count_r;
        end
    end

    assign bus.taken_count = taken_count_r;
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: driver runs a cycle-level reference model
// and queues expectations; a monitor compares them after each rising edge.
module tb_pc_redirect_ctrl;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_redirect_ctrl_if bus();

    pc_redirect_ctrl #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: flush is a count of remaining squash cycles
    logic [31:0] m_pc;
    int          m_rem = 0;
    int          m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic rst, input logic bt, input logic [31:0] tgt, input logic st);
        exp_t e;
        @(negedge clk);
        reset             = rst;
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
        bus.stall         = st;
        e.mis = 1'b0;
        if (rst) begin
            m_pc  = RESET_PC;
            m_rem = 0;
            m_cnt = 0;
        end else if (m_rem == 0 && bt) begin
            m_pc  = tgt & 32'hFFFF_FFFC;
            m_rem = FLUSH_CYCLES;
            e.mis = ((tgt % 32'd4) != 32'd0);
            if (m_cnt < 65535) m_cnt++;
        end else begin
            if (!st) m_pc = m_pc + 32'd4;
            if (m_rem > 0) m_rem--;
        end
        e.pc    = m_pc;
        e.flush = (m_rem > 0);
        e.cnt   = 16'(m_cnt);
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per clock once the driver has started
    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc",          bus.pc,                         e.pc);
            check("if_id_flush", {31'd0, bus.if_id_flush},       {31'd0, e.flush});
            check("id_ex_flush", {31'd0, bus.id_ex_flush},       {31'd0, e.flush});
            check("busy",        {31'd0, bus.redirect_busy},     {31'd0, e.flush});
            check("misaligned",  {31'd0, bus.target_misaligned}, {31'd0, e.mis});
`ifdef PC_BRANCH_STATS_EN
            check("taken_count", {16'd0, bus.taken_count},       {16'd0, e.cnt});
`endif
        end
    end

    initial begin
        logic        r_rst, r_bt, r_st;
        logic [31:0] r_tgt;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.stall         = 1'b0;

        // Reset then idle: pc 0,4,8,C,10
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Redirect at pc=8 to 0x100
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Branch beats stall; stall keeps pc while flush times out
        step(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Branches during FLUSH are ignored
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);

        // Misaligned target, then pc wrap at the top of the address space
        step(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Branch on the first RUN cycle after a flush is accepted
        step(1'b0, 1'b1, 32'h0000_0600, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0700, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Reset in the first FLUSH cycle, and reset overriding branch+stall
        step(1'b0, 1'b1, 32'h0000_0300, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0500, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 63) == 0);
            r_bt  = ($urandom_range(0, 3) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_tgt = $urandom;
            if ($urandom_range(0, 7) == 0) r_tgt = 32'hFFFF_FFE0 | (r_tgt & 32'h0000_001F);
            step(r_rst, r_bt, r_tgt, r_st);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports named `clk` and `reset`.
REQ-002 Parameter `RESET_PC`, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-003 Parameter `FLUSH_CYCLES`, default 2, legal range 1..7, SHALL set the number of cycles the flush outputs stay asserted after a redirect.
REQ-004 `clk` SHALL be an input, 1 bit: the rising-edge clock.
REQ-005 `reset` SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-006 `branch_taken` SHALL be an input, 1 bit: registered branch decision (Branch AND Zero) from the MEM stage.
REQ-007 `branch_target` SHALL be an input, 32 bits: redirect address, valid when `branch_taken`=1.
REQ-008 `stall` SHALL be an input, 1 bit: hazard unit request to hold the PC.
REQ-009 `pc` SHALL be an output, 32 bits: registered fetch address.
REQ-010 `if_id_flush` SHALL be an output, 1 bit: registered squash of the IF/ID register.
REQ-011 `id_ex_flush` SHALL be an output, 1 bit: registered squash of the ID/EX register.
REQ-012 `redirect_busy` SHALL be an output, 1 bit: high while the state machine is not in RUN.
REQ-013 `target_misaligned` SHALL be an output, 1 bit: one-cycle pulse when an accepted target has bits [1:0] not equal to 0.
REQ-014 `taken_count` SHALL be an output, 16 bits, and SHALL exist only when `PC_BRANCH_STATS_EN` is defined.

Function
REQ-015 State machine states SHALL be RUN and FLUSH, together with a 3-bit down-counter `flush_cnt`.
REQ-016 In RUN, `branch_taken`=1 SHALL be accepted. On the next edge:
- `pc` <= {`branch_target`[31:2], 2'b00};
- state <= FLUSH;
- `flush_cnt` <= `FLUSH_CYCLES`-1.
REQ-017 Branch SHALL take priority over stall: an accepted branch redirects even when `stall`=1.
REQ-018 In RUN with `branch_taken`=0 and `stall`=1, `pc` SHALL hold its value.
REQ-019 In RUN with `branch_taken`=0 and `stall`=0, `pc` <= `pc`+4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-020 In FLUSH, `if_id_flush` and `id_ex_flush` SHALL both be 1, and `redirect_busy` SHALL be 1.
REQ-021 In FLUSH, `flush_cnt` SHALL decrement each cycle; when it is 0, the next state SHALL be RUN.
REQ-022 Flush SHALL therefore last exactly `FLUSH_CYCLES` cycles, starting the cycle after acceptance.
REQ-023 In FLUSH, `branch_taken` SHALL be ignored, because it originates from squashed instructions.
REQ-024 In FLUSH, `pc` SHALL advance by 4 per cycle when `stall`=0 and hold when `stall`=1; the counter SHALL decrement regardless of `stall`.
REQ-025 `target_misaligned` SHALL be asserted for exactly one cycle, coincident with the first FLUSH cycle of an accepted branch whose target[1:0] is not 0.
REQ-026 Redirect latency SHALL be 1 cycle: the sampled target appears on `pc` the cycle after `branch_taken`.
REQ-027 A branch on the cycle FLUSH returns to RUN SHALL be accepted normally.

Reset
REQ-028 `reset`=1 at a clock edge SHALL force the following, overriding any branch or stall:
- `pc`=`RESET_PC`;
- state=RUN;
- `flush_cnt`=0;
- `if_id_flush`=0, `id_ex_flush`=0, `redirect_busy`=0, `target_misaligned`=0;
- `taken_count`=0.
REQ-029 Reset asserted mid-FLUSH SHALL abort the flush immediately, with no residual flush cycles after reset is released.
REQ-030 The first cycle after reset is released SHALL be a normal RUN cycle.

Configuration
REQ-031 With `PC_BRANCH_STATS_EN` defined, `taken_count` SHALL increment by 1 for each accepted branch, saturate at 16'hFFFF, and clear on reset.
REQ-032 Without `PC_BRANCH_STATS_EN`, the `taken_count` port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Scenario: reset, then 4 idle cycles with `RESET_PC`=0 -> `pc` reads 0,4,8,C,10; both flushes stay 0.
REQ-034 Scenario: `branch_taken`=1, target 32'h0000_0100, at `pc`=8 -> next `pc`=100; flushes high for 2 cycles; `pc` then reads 104,108; then RUN.
REQ-035 Scenario: `stall`=1 with `branch_taken`=1, target 32'h40 -> `pc`=40 next cycle; then with `stall` held, `pc` stays 40 and flush still ends after 2 cycles.
REQ-036 Scenario: `branch_taken` pulsed during FLUSH with target 32'h200 -> ignored; `pc` never equals 200; `taken_count` (if enabled) increments only once.
REQ-037 Scenario: target 32'h0000_0103 -> `pc`=100 and `target_misaligned` pulses for 1 cycle; separately, `pc`=FFFF_FFFC with no stall -> next `pc`=0.
REQ-038 Scenario: reset asserted in the first FLUSH cycle -> next cycle `pc`=`RESET_PC`, flushes 0, `redirect_busy` 0.
